// File: rtl/pb_event_queue.sv
// Push-button front end: synchronise and debounce a raw button bus, turn each debounced
// press into a channel-index event, and buffer events in a show-ahead FIFO.
module pb_event_queue #(
    parameter int unsigned N         = 21,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned DB_CYCLES = 3,
    localparam int unsigned CW       = $clog2(N),
    localparam int unsigned AW       = $clog2(DEPTH)
) (
    input  logic          hz100,
    input  logic          reset,
    input  logic [N-1:0]  pb,
    input  logic          pop,
    input  logic          clr_ovf,
    output logic          valid,
    output logic [CW-1:0] code,
    output logic [AW:0]   count,
    output logic [N-1:0]  pressed,
    output logic          overflow
);

    localparam int unsigned DBW = $clog2(DB_CYCLES + 1);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    logic [N-1:0]   s1_q, s2_q;
    logic [N-1:0]   pressed_q, pressed_d;
    logic [N-1:0]   pend_q, pend_d;
    logic [N-1:0]   rise, clr_mask;
    logic [DBW-1:0] cnt_q [N];
    logic [DBW-1:0] cnt_d [N];

    logic [CW-1:0]  mem_q [DEPTH];
    logic [AW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]    count_q, count_d;
    logic           overflow_q, overflow_d;

    logic           pop_ok, can_push, push;
    logic [CW-1:0]  push_idx;

    // Debounce: a level changes only after DB_CYCLES consecutive disagreeing samples.
    always_comb begin
        for (int i = 0; i < int'(N); i++) begin
            cnt_d[i]     = '0;
            pressed_d[i] = pressed_q[i];
            if (s2_q[i] != pressed_q[i]) begin
                if (cnt_q[i] + DBW'(1) == DBW'(DB_CYCLES)) begin
                    pressed_d[i] = s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + DBW'(1);
                end
            end
        end
    end

    assign rise = pressed_d & ~pressed_q;

    // Lowest-index pending channel wins the single push slot.
    always_comb begin
        push_idx = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                push_idx = CW'(i);
            end
        end
    end

    assign pop_ok   = pop & valid;
    assign can_push = (count_q != FULL) | pop_ok;
    assign push     = (|pend_q) & can_push;
    assign clr_mask = push ? (N'(1) << push_idx) : '0;

    always_comb begin
        pend_d     = (pend_q & ~clr_mask) | rise;
        overflow_d = (|(rise & pend_q & ~clr_mask)) | (overflow_q & ~clr_ovf);
        wptr_d     = push ? wptr_q + AW'(1) : wptr_q;
        rptr_d     = pop_ok ? rptr_q + AW'(1) : rptr_q;
        count_d    = count_q;
        if (push && !pop_ok) begin
            count_d = count_q + (AW + 1)'(1);
        end else if (!push && pop_ok) begin
            count_d = count_q - (AW + 1)'(1);
        end
    end

    always_ff @(posedge hz100) begin
        if (reset) begin
            s1_q       <= '0;
            s2_q       <= '0;
            pressed_q  <= '0;
            pend_q     <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < int'(N); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q       <= pb;
            s2_q       <= s1_q;
            pressed_q  <= pressed_d;
            pend_q     <= pend_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            for (int i = 0; i < int'(N); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Storage needs no reset: pointers and count define which entries are live.
    always_ff @(posedge hz100) begin
        if (!reset && push) begin
            mem_q[wptr_q] <= push_idx;
        end
    end

    assign valid    = (count_q != '0);
    assign code     = valid ? mem_q[rptr_q] : '0;
    assign count    = count_q;
    assign pressed  = pressed_q;
    assign overflow = overflow_q;

endmodule

// File: doc/pb_event_queue.md
# pb_event_queue

Parametrised push-button front end for the board top level. It synchronises and debounces an N-channel raw button bus clocked from `hz100`, then turns each debounced press (rising edge) into a key-code event. Events are buffered in a DEPTH-entry show-ahead FIFO, and game/control logic drains the FIFO one event per `pop`. The block also exposes the debounced levels and a sticky overflow flag, so the top level no longer needs to poll `pb` directly.

## Interface
- `N`, 21: number of button channels; must be ≥2.
- `DEPTH`, 8: FIFO entries; must be a power of two, ≥2.
- `DB_CYCLES`, 3: consecutive stable synchronised samples required to change a debounced level; must be ≥1.
- Derived: `CW = $clog2(N)`; `AW = $clog2(DEPTH)`.

Ports:
- `hz100` input, 1: the single clock. All state updates on its rising edge.
- `reset` input, 1: synchronous, active-high reset.
- `pb` input, N: raw, asynchronous button levels. 1 = pressed.
- `pop` input, 1: consume the head event. Ignored when `valid`=0.
- `clr_ovf` input, 1: clears `overflow`.
- `valid` output, 1: FIFO non-empty.
- `code` output, CW: channel index of the head event. Forced to 0 when `valid`=0.
- `count` output, AW+1: number of FIFO entries, range 0..DEPTH.
- `pressed` output, N: debounced levels.
- `overflow` output, 1: sticky flag; a press event was lost.

## Operation
- **Synchroniser:** a 2-flop chain per channel, `pb` → `s1` → `s2`.
- **Debounce, per channel:**
  - Counter width is `$clog2(DB_CYCLES+1)`.
  - When `s2` equals `pressed[i]`, the counter is set to 0.
  - Otherwise the counter increments.
  - On the cycle the increment would reach `DB_CYCLES`, `pressed[i]` takes the value of `s2` and the counter is set to 0.
  - A disagreement shorter than `DB_CYCLES` cycles never changes `pressed`.
- **Press detect:**
  - `rise[i]` is combinational: true on the cycle `pressed[i]` is about to go 0→1.
  - `rise[i]` sets `pend[i]` at that edge.
  - Falling edges generate nothing.
- **Enqueue arbiter:**
  - Each cycle the lowest-index set `pend` bit is pushed, as its index, if the FIFO can accept it.
  - The FIFO can accept when `count` < DEPTH, or when `count` = DEPTH and a legal pop occurs in the same cycle.
  - The pushed channel's `pend` bit is cleared.
  - At most one push per cycle. Higher-index pending bits wait; nothing is dropped while it is pending.
- **Overflow:**
  - `rise[i]` while `pend[i]` is already set and is not cleared this cycle → that event is lost and `overflow` is set to 1.
  - `overflow` stays 1 until `clr_ovf`=1 or `reset`.
  - If set and clear occur in the same cycle, set wins.
- **FIFO:**
  - Show-ahead: `code` shows the head entry whenever `valid`=1.
  - Circular buffer; read and write pointers are AW bits and wrap modulo DEPTH.
  - `count` increments on push-only, decrements on pop-only, and is unchanged on push+pop.
  - Push+pop when full is legal: `count` stays DEPTH.
  - Push+pop when empty is impossible, because a pop is ignored when `valid`=0.
- **Reset:** clears `s1`, `s2`, all counters, `pressed`, `pend`, both pointers, `count`, and `overflow`.
  - Outputs after reset: `valid`=0, `code`=0, `count`=0, `pressed`=0, `overflow`=0.
  - A button held through reset produces one fresh event after reset deasserts.
  - Reset mid-operation discards all queued and pending events.

## Timing
- `pb[i]` rises and is stable before edge 1:
  - `s2` = 1 after edge 2.
  - `pressed[i]` = 1 after edge 2+DB_CYCLES.
  - Pushed at edge 3+DB_CYCLES, so `valid`=1 and `code`=i from that edge, if the FIFO was empty and no lower-index bit is pending.
- Release latency is symmetric: `pressed[i]` = 0 after edge 2+DB_CYCLES.
- A pop at edge k:
  - Head advances after edge k.
  - `valid` drops after edge k if `count` was 1 with no simultaneous push.
- The FIFO has no bypass. An event pushed at edge k is poppable no earlier than edge k+1.
- `pend` clears at the same edge as the push. A new `rise` on that channel in that same cycle sets `pend` again, with no overflow.

## Test plan
- **Single press, `DB_CYCLES`=3:** raise `pb[7]` before edge 1 and hold → `pressed[7]` = 1 after edge 5; `valid`=1, `code`=7, `count`=1 after edge 6. Pulse `pop` → `valid`=0, `code`=0.
- **Bounce rejection:** `pb[4]` high for 2 cycles, then low, then high for 2 cycles → `pressed[4]` stays 0; no event; `count`=0.
- **Simultaneous presses:** `pb[5]` and `pb[2]` rise on the same cycle → `code`=2 enqueued at edge 6, 5 enqueued at edge 7; pops return 2 then 5.
- **Full FIFO:** press 9 distinct channels 0..8 with no pops → `count`=8, `pend[8]`=1, `overflow`=0. One pop → channel 8 pushed on the same edge, `count` remains 8. Draining yields 0..8 in order, and the pointers wrap.
- **Overflow:**
  - With the FIFO full, press, release and re-press channel 8 → `overflow`=1.
  - `clr_ovf` pulse → `overflow`=0.
  - `clr_ovf` coincident with a new loss → `overflow` stays 1.
- **Reset mid-operation:** with `count`=3 and `pressed[1]` held, assert `reset` for 1 cycle → all outputs 0. With `pb[1]` still high, a fresh `code`=1 event appears DB_CYCLES+3 edges after reset deasserts.
